// File: rtl/run_ctrl_pkg.sv
// Shared types and defaults for the core run controller and its benches.
package run_ctrl_pkg;

   typedef enum logic [2:0] {
      IDLE,
      HOLD,
      RUN,
      DONE,
      TOUT
   } run_state_t;

   localparam int DEFAULT_RESET_CYCLES = 5;
   localparam int DEFAULT_TIMEOUT      = 100000;

   function automatic logic is_busy(input run_state_t s);
      return (s == HOLD) || (s == RUN);
   endfunction

endpackage

// File: rtl/run_controller.sv
// Drives the core's reset for a fixed interval, times the run until done or
// watchdog expiry, and holds the result until the next start request.
module run_controller
   import run_ctrl_pkg::*;
#(
   parameter int RESET_CYCLES = DEFAULT_RESET_CYCLES,
   parameter int TIMEOUT      = DEFAULT_TIMEOUT,
   parameter int CNT_W        = 32,
   parameter int PROG_W       = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [PROG_W-1:0] prog_id,
   output logic              core_reset,
   output logic [PROG_W-1:0] core_prog,
   input  logic              core_done,
   output logic              busy,
   output logic              finished,
   output logic              timed_out,
   output logic [CNT_W-1:0]  cycle_count
);

   localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(TIMEOUT);

   generate
      if (RESET_CYCLES < 1 || TIMEOUT < 1 ||
          ((64'd1 << CNT_W) - 64'd1) < 64'(TIMEOUT)) begin : g_param_check
         $error("run_controller: RESET_CYCLES/TIMEOUT must be >=1 and TIMEOUT must fit in CNT_W");
      end
   endgenerate

   run_state_t        state_q, state_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [PROG_W-1:0] prog_q, prog_d;
   logic              core_reset_q, core_reset_d;
   logic              busy_q, busy_d;
   logic              fin_q, fin_d;
   logic              to_q, to_d;

   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      count_d = count_q;
      prog_d  = prog_q;
      fin_d   = fin_q;
      to_d    = to_q;
      case (state_q)
         IDLE, DONE, TOUT: begin
            if (start) begin
               state_d = HOLD;
               hold_d  = HOLD_LOAD;
               count_d = '0;
               prog_d  = prog_id;
               fin_d   = 1'b0;
               to_d    = 1'b0;
            end
         end
         HOLD: begin
            if (hold_q == '0) begin
               state_d = RUN;
            end else begin
               hold_d = hold_q - 1'b1;
            end
         end
         RUN: begin
            // done takes priority over the watchdog boundary on the same edge
            if (core_done) begin
               state_d = DONE;
               fin_d   = 1'b1;
            end else if (count_q == CNT_LAST) begin
               state_d = TOUT;
               count_d = CNT_LIMIT;
               to_d    = 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      core_reset_d = (state_d != RUN);
      busy_d       = is_busy(state_d);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q <= '0;
      end else begin
         hold_q <= hold_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         core_reset_q <= 1'b1;
         busy_q       <= 1'b0;
         prog_q       <= '0;
         fin_q        <= 1'b0;
         to_q         <= 1'b0;
      end else begin
         core_reset_q <= core_reset_d;
         busy_q       <= busy_d;
         prog_q       <= prog_d;
         fin_q        <= fin_d;
         to_q         <= to_d;
      end
   end

   assign core_reset  = core_reset_q;
   assign core_prog   = prog_q;
   assign busy        = busy_q;
   assign finished    = fin_q;
   assign timed_out   = to_q;
   assign cycle_count = count_q;

endmodule

// File: tb/tb_run_controller.sv
// Self-checking bench for run_controller: table-driven runs, corner sequences
// and randomized traffic against a time-indexed reference model.
module tb_run_controller;
   import run_ctrl_pkg::*;

   localparam int RC = DEFAULT_RESET_CYCLES;
   localparam int TO = 40;
   localparam int CW = 32;
   localparam int PW = 2;

   logic          clk;
   logic          reset;
   logic          start;
   logic [PW-1:0] prog_id;
   logic          core_reset;
   logic [PW-1:0] core_prog;
   logic          core_done;
   logic          busy;
   logic          finished;
   logic          timed_out;
   logic [CW-1:0] cycle_count;

   run_controller #(
      .RESET_CYCLES(RC),
      .TIMEOUT     (TO),
      .CNT_W       (CW),
      .PROG_W      (PW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .prog_id    (prog_id),
      .core_reset (core_reset),
      .core_prog  (core_prog),
      .core_done  (core_done),
      .busy       (busy),
      .finished   (finished),
      .timed_out  (timed_out),
      .cycle_count(cycle_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: a run is described by the number of edges since the
   // start edge; edges 1..RC are the reset interval, later edges are RUN edges.
   bit m_run;
   int m_k;
   int m_prog;
   int m_count;
   bit m_fin;
   bit m_to;

   typedef struct {
      int prog;
      int delay;       // done seen on RUN edge delay+1; -1 = never
      int stuck;       // done high from the start request onwards
      int start_held;  // keep start high for the whole run
      int exp_count;
      int exp_fin;
      int exp_to;
   } vec_t;

   vec_t vecs[7];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_run = 0; m_k = 0; m_prog = 0; m_count = 0; m_fin = 0; m_to = 0;
   endtask

   task automatic check_all(input string tag);
      chk({tag, " core_reset"}, 64'(core_reset), 64'(!(m_run && m_k >= RC)));
      chk({tag, " busy"}, 64'(busy), 64'(m_run));
      chk({tag, " core_prog"}, 64'(core_prog), 64'(m_prog));
      chk({tag, " finished"}, 64'(finished), 64'(m_fin));
      chk({tag, " timed_out"}, 64'(timed_out), 64'(m_to));
      chk({tag, " cycle_count"}, 64'(cycle_count), 64'(m_count));
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      if (!m_run) begin
         if (start) begin
            m_run = 1; m_k = 0; m_prog = int'(prog_id);
            m_count = 0; m_fin = 0; m_to = 0;
         end
      end else begin
         m_k++;
         if (m_k > RC) begin
            if (core_done) begin
               m_run = 0; m_fin = 1;
            end else if (m_count + 1 == TO) begin
               m_run = 0; m_count = TO; m_to = 1;
            end else begin
               m_count++;
            end
         end
      end
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int guard = 0;
      int hold_len = 0;
      prog_id   = PW'(v.prog);
      start     = 1'b1;
      core_done = (v.stuck != 0);
      do begin
         step(nm);
         guard++;
         if (busy && core_reset) hold_len++;
         start     = (v.start_held != 0);
         core_done = (v.stuck != 0) || (m_run && v.delay >= 0 && m_k >= RC + v.delay);
      end while (m_run && guard < 200);
      start     = 1'b0;
      core_done = 1'b0;
      if (guard >= 200) begin
         n_cmp++; n_bad++;
         $display("FAIL %s run_bound: got %0d cycles, want < 200", nm, guard);
      end
      chk({nm, " hold_len"}, 64'(hold_len), 64'(RC));
      chk({nm, " count"}, 64'(cycle_count), 64'(v.exp_count));
      chk({nm, " finished"}, 64'(finished), 64'(v.exp_fin));
      chk({nm, " timed_out"}, 64'(timed_out), 64'(v.exp_to));
      chk({nm, " prog"}, 64'(core_prog), 64'(v.prog));
      chk({nm, " core_reset"}, 64'(core_reset), 64'd1);
      step({nm, " hold1"});
      step({nm, " hold2"});
      chk({nm, " count_held"}, 64'(cycle_count), 64'(v.exp_count));
      $display("run %s: prog=%0d count=%0d finished=%0d timed_out=%0d", nm,
               core_prog, cycle_count, finished, timed_out);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got no end of test, want $finish before 1 ms");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int guard;
      vecs[0] = '{2, 37, 0, 0, 37, 1, 0};      // normal done
      vecs[1] = '{1, -1, 0, 0, TO, 0, 1};      // never done: watchdog
      vecs[2] = '{3, TO - 1, 0, 0, TO - 1, 1, 0}; // done on the TIMEOUT-th RUN edge
      vecs[3] = '{0, TO, 0, 0, TO, 0, 1};      // done one edge too late
      vecs[4] = '{1, 0, 1, 1, 0, 1, 0};        // done stuck through HOLD, start spam
      vecs[5] = '{2, 0, 0, 0, 0, 1, 0};        // done on the first RUN edge
      vecs[6] = '{3, 1, 0, 1, 1, 1, 0};        // short run with start held

      reset = 1'b1; start = 1'b0; prog_id = '0; core_done = 1'b0;
      model_reset();
      @(negedge clk);
      check_all("por");
      @(negedge clk);
      reset = 1'b0;
      step("idle");

      for (int i = 0; i < 7; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // Reset pulse between edges at RUN cycle 10, then a clean run.
      prog_id = 2'd2;
      start   = 1'b1;
      step("rst_run");
      start = 1'b0;
      guard = 0;
      while (!(m_run && m_k == RC + 10) && guard < 100) begin
         step("rst_run");
         guard++;
      end
      chk("rst_run reached_cycle10", 64'(cycle_count), 64'd10);
      #2 reset = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      @(negedge clk);
      reset = 1'b0;
      check_all("after_rst");
      run_vec('{1, 12, 0, 0, 12, 1, 0}, "post_rst");

      // Randomized traffic, with occasional mid-cycle async reset pulses.
      for (int c = 0; c < 3000; c++) begin
         start     = ($urandom_range(0, 7) == 0);
         prog_id   = PW'($urandom_range(0, 3));
         core_done = ($urandom_range(0, 49) == 0);
         step("rand");
         if ($urandom_range(0, 399) == 0) begin
            #2 reset = 1'b1;
            #1;
            model_reset();
            check_all("rand_rst");
            #1 reset = 1'b0;
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
